// File: rtl/add_mul_sgn_seq.sv
// rtl/add_mul_sgn_seq.sv - sequential signed (XS+XC)*Y, radix-2 Booth, one Y bit per cycle.
// Optional accumulate mode (P += product) under macro ADD_MUL_SGN_SEQ_ACC_EN.
module add_mul_sgn_seq #(
  parameter int widthX = 8,
  parameter int widthY = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [widthX-1:0]        XS,
  input  logic [widthX-1:0]        XC,
  input  logic [widthY-1:0]        Y,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
`ifdef ADD_MUL_SGN_SEQ_ACC_EN
  input  logic                     ACC,
`endif
  output logic [widthX+widthY:0]   P
);

  localparam int PW = widthX + widthY + 1;
  localparam int CW = $clog2(widthY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [widthY-1:0] y_q, y_d;
  logic              ybit_q, ybit_d;
  logic [PW-1:0]     m_q, m_d;
  logic [PW-1:0]     part_q, part_d;
  logic [PW-1:0]     p_q, p_d;

  logic [widthX:0]   sum;
  logic [PW-1:0]     booth;

  // Sum is one bit wider than the addends so it can never overflow.
  assign sum = {XS[widthX-1], XS} + {XC[widthX-1], XC};

  // y_q shifts right each step, so bit 0 is always the current Booth digit.
  always_comb begin
    booth = part_q;
    case ({y_q[0], ybit_q})
      2'b01:   booth = part_q + m_q;
      2'b10:   booth = part_q - m_q;
      default: booth = part_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ybit_d  = ybit_q;
    m_d     = m_q;
    part_d  = part_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          state_d = BUSY;
          cnt_d   = '0;
          y_d     = Y;
          ybit_d  = 1'b0;
          m_d     = {{(PW-widthX-1){sum[widthX]}}, sum};
`ifdef ADD_MUL_SGN_SEQ_ACC_EN
          part_d  = ACC ? p_q : '0;
`else
          part_d  = '0;
`endif
        end
      end
      BUSY: begin
        part_d = booth;
        m_d    = m_q << 1;
        y_d    = y_q >> 1;
        ybit_d = y_q[0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(widthY - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          p_d     = booth;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      ybit_q  <= 1'b0;
      m_q     <= '0;
      part_q  <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ybit_q  <= ybit_d;
      m_q     <= m_d;
      part_q  <= part_d;
      p_q     <= p_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign P         = p_q;

endmodule

// File: doc/add_mul_sgn_seq.md
ADD_MUL_SGN_SEQ -- requirements
Module: add_mul_sgn_seq

Interface
REQ-001 SHALL have parameter widthX, default 8, word width of XS and XC (>= 2).
REQ-002 SHALL have parameter widthY, default 8, word width of Y (>= 2).
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port IN_VALID, input, 1, operand set valid.
REQ-006 SHALL have port IN_READY, output, 1, block can accept operands.
REQ-007 SHALL have port XS, input, widthX, signed addend (two's complement).
REQ-008 SHALL have port XC, input, widthX, signed addend (two's complement).
REQ-009 SHALL have port Y, input, widthY, signed multiplicand.
REQ-010 SHALL have port OUT_VALID, output, 1, product valid.
REQ-011 SHALL have port OUT_READY, input, 1, consumer accepts product.
REQ-012 SHALL have port P, output, widthX+widthY+1, signed product register.

Function
REQ-013 SHALL compute P = (XS+XC)*Y exactly: sum sign-extended to widthX+1 bits, no overflow for any input.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 SHALL assert IN_READY only in IDLE; OUT_VALID only in DONE.
REQ-016 SHALL accept operands on a rising edge where IN_VALID=1 and IN_READY=1, registering XS+XC and Y, and go IDLE->BUSY.
REQ-017 SHALL ignore XS, XC, Y and IN_VALID outside IDLE; operand changes during BUSY/DONE do not affect P.
REQ-018 SHALL in BUSY process one bit of Y per cycle via radix-2 Booth recoding (pair y[i], y[i-1], y[-1]=0: 01 add, 10 subtract, 00/11 none), using a counter of width clog2(widthY).
REQ-019 SHALL go BUSY->DONE on the edge completing bit widthY-1, i.e. OUT_VALID rises exactly widthY edges after the accepting edge.
REQ-020 SHALL hold P and OUT_VALID stable in DONE until OUT_READY=1, then go DONE->IDLE on that edge.
REQ-021 SHALL not accept new operands in the DONE->IDLE edge; minimum issue interval is widthY+2 cycles.
REQ-022 SHALL keep P holding the last completed product in IDLE and BUSY; P updates only on the BUSY->DONE edge.
REQ-023 SHALL handle Y = most-negative value and XS+XC = -2^widthX without saturation or wrap.

Reset
REQ-024 SHALL on RST=1, independent of CLK, force state IDLE, counter 0, P=0, OUT_VALID=0, IN_READY=1 after release.
REQ-025 SHALL discard any in-flight operation on reset mid-BUSY or mid-DONE; no OUT_VALID is produced for it.

Configuration
REQ-026 SHALL support macro ADD_MUL_SGN_SEQ_ACC_EN; when defined, add input port ACC (1 bit) sampled with operands at acceptance.
REQ-027 SHALL with ADD_MUL_SGN_SEQ_ACC_EN and captured ACC=1 produce P = P_prev + (XS+XC)*Y, modulo 2^(widthX+widthY+1); ACC=0 behaves as REQ-013.
REQ-028 SHALL with ADD_MUL_SGN_SEQ_ACC_EN, reset P to 0 so the first accumulation starts from zero.
REQ-029 SHALL without the macro have no ACC port and no accumulate datapath; P always per REQ-013.

Verification (widthX=widthY=8, P 17 bits)
REQ-030 SHALL cover basic: XS=3, XC=4, Y=-5 accepted at edge k -> OUT_VALID=1 after edge k+8, P=-35.
REQ-031 SHALL cover extremes: XS=-128, XC=-128, Y=-128 -> P=32768; XS=127, XC=127, Y=-128 -> P=-32512.
REQ-032 SHALL cover back-pressure: OUT_READY=0 for 5 cycles in DONE -> P and OUT_VALID held, IN_READY=0, new IN_VALID ignored; OUT_READY=1 -> IDLE next edge.
REQ-033 SHALL cover reset mid-BUSY: RST pulsed 4 cycles after acceptance -> P=0, OUT_VALID=0, IN_READY=1 immediately, no spurious output.
REQ-034 SHALL cover operand change during BUSY: XS/XC/Y toggled randomly -> P equals product of captured values.
REQ-035 SHALL cover ACC (macro defined): ops (1,1,10,ACC=0) then (2,3,-4,ACC=1) -> P=20 then P=0.
